// File: rtl/snake_move_unit_if.sv
// Signal bundle between snake_move_unit and its game-control, food and renderer neighbours.
interface snake_move_unit_if;
  logic [1:0] gameStatus;
  logic       restart;
  logic       key1_press;
  logic       key2_press;
  logic       key3_press;
  logic       key4_press;
  logic       grow;
  logic [5:0] cell_x;
  logic [4:0] cell_y;
  logic       cell_is_head;
  logic       cell_is_body;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [4:0] snake_len;
  logic       step_done;
  logic       hit_wall;
  logic       hit_body;

  modport master (
    output gameStatus, restart, key1_press, key2_press, key3_press, key4_press, grow,
           cell_x, cell_y,
    input  cell_is_head, cell_is_body, head_x, head_y, snake_len, step_done,
           hit_wall, hit_body
  );

  modport slave (
    input  gameStatus, restart, key1_press, key2_press, key3_press, key4_press, grow,
           cell_x, cell_y,
    output cell_is_head, cell_is_body, head_x, head_y, snake_len, step_done,
           hit_wall, hit_body
  );
endinterface

// File: rtl/snake_move_unit.sv
// Snake body/motion engine: stepping, steering, growth, collisions and cell occupancy queries.
// Optional macro WRAP_WALLS_EN: leaving the grid wraps to the opposite edge instead of hitting a wall.
module snake_move_unit #(
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int MAX_LEN     = 16,
  parameter int STEP_CYCLES = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  snake_move_unit_if.slave bus
);

  localparam int              CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [1:0]      ST_PLAY   = 2'b10;
  localparam logic [1:0]      DIR_UP    = 2'd0;
  localparam logic [1:0]      DIR_DOWN  = 2'd1;
  localparam logic [1:0]      DIR_LEFT  = 2'd2;
  localparam logic [1:0]      DIR_RIGHT = 2'd3;
  localparam logic [4:0]      LEN_INIT  = 5'd3;
  localparam logic [4:0]      LEN_MAX   = 5'(MAX_LEN);
  localparam int              INIT_X    = 20;
  localparam int              INIT_Y    = 15;

  // Segment word is {x[5:0], y[4:0]}; slot 0 is the head.
  logic [10:0]      seg_r [MAX_LEN];
  logic [1:0]       dir_r;
  logic [1:0]       pend_r;
  logic             grow_pend_r;
  logic [CNT_W-1:0] cnt_r;
  logic [4:0]       len_r;
  logic             step_done_r;
  logic             hit_wall_r;
  logic             hit_body_r;

  logic             run_s;
  logic             tick_s;
  logic             len_room_s;
  logic             growing_s;
  logic [6:0]       nx_w_s;
  logic [5:0]       ny_w_s;
  logic [5:0]       nx_s;
  logic [4:0]       ny_s;
  logic             off_grid_s;
  logic             body_hit_s;
  logic             move_s;
  logic [1:0]       dir_eff_s;
  logic [1:0]       key_dir_s;
  logic             key_vld_s;
  logic             key_ok_s;
  logic             cell_body_s;

  function automatic logic [10:0] init_seg(input int idx);
    if (idx < 3) begin
      return {6'(INIT_X - idx), 5'(INIT_Y)};
    end else begin
      return 11'd0;
    end
  endfunction

  assign run_s      = (bus.gameStatus == ST_PLAY) && !hit_wall_r && !hit_body_r;
  assign tick_s     = run_s && (cnt_r == CNT_LAST);
  assign len_room_s = (len_r < LEN_MAX);
  assign growing_s  = grow_pend_r | (bus.grow & len_room_s);

  // Candidate head cell, one bit wider so -1 and overflow are visible.
  always_comb begin
    nx_w_s = {1'b0, seg_r[0][10:5]};
    ny_w_s = {1'b0, seg_r[0][4:0]};
    case (pend_r)
      DIR_UP:    ny_w_s = {1'b0, seg_r[0][4:0]} - 6'd1;
      DIR_DOWN:  ny_w_s = {1'b0, seg_r[0][4:0]} + 6'd1;
      DIR_LEFT:  nx_w_s = {1'b0, seg_r[0][10:5]} - 7'd1;
      DIR_RIGHT: nx_w_s = {1'b0, seg_r[0][10:5]} + 7'd1;
      default: begin
        nx_w_s = {1'b0, seg_r[0][10:5]};
        ny_w_s = {1'b0, seg_r[0][4:0]};
      end
    endcase
  end

`ifdef WRAP_WALLS_EN
  // Fold out-of-range coordinates back onto the opposite edge.
  always_comb begin
    off_grid_s = 1'b0;
    if (nx_w_s == 7'h7F) begin
      nx_s = 6'(GRID_W - 1);
    end else if (nx_w_s >= 7'(GRID_W)) begin
      nx_s = 6'd0;
    end else begin
      nx_s = nx_w_s[5:0];
    end
    if (ny_w_s == 6'h3F) begin
      ny_s = 5'(GRID_H - 1);
    end else if (ny_w_s >= 6'(GRID_H)) begin
      ny_s = 5'd0;
    end else begin
      ny_s = ny_w_s[4:0];
    end
  end
`else
  // Unsigned compare catches both -1 (all ones) and running past the far edge.
  always_comb begin
    nx_s       = nx_w_s[5:0];
    ny_s       = ny_w_s[4:0];
    off_grid_s = (nx_w_s >= 7'(GRID_W)) || (ny_w_s >= 6'(GRID_H));
  end
`endif

  // The tail slot only blocks when it stays put because the snake grows this step.
  always_comb begin
    body_hit_s = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (seg_r[i] == {nx_s, ny_s}) begin
        if (5'(i) < (len_r - 5'd1)) begin
          body_hit_s = 1'b1;
        end else if ((5'(i) == (len_r - 5'd1)) && growing_s) begin
          body_hit_s = 1'b1;
        end else begin
          body_hit_s = body_hit_s;
        end
      end else begin
        body_hit_s = body_hit_s;
      end
    end
  end

  assign move_s    = tick_s && !off_grid_s && !body_hit_s;
  assign dir_eff_s = move_s ? pend_r : dir_r;

  // Key priority decode: key1 > key2 > key3 > key4.
  always_comb begin
    key_vld_s = 1'b1;
    key_dir_s = DIR_UP;
    if (bus.key1_press) begin
      key_dir_s = DIR_UP;
    end else if (bus.key2_press) begin
      key_dir_s = DIR_DOWN;
    end else if (bus.key3_press) begin
      key_dir_s = DIR_LEFT;
    end else if (bus.key4_press) begin
      key_dir_s = DIR_RIGHT;
    end else begin
      key_vld_s = 1'b0;
    end
  end

  // Opposite directions differ only in bit 0.
  assign key_ok_s = key_vld_s && (key_dir_s != {dir_eff_s[1], ~dir_eff_s[0]});

  // Segment storage: reinitialise, or shift toward the tail on a move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) seg_r[i] <= init_seg(i);
    end else if (bus.restart) begin
      for (int i = 0; i < MAX_LEN; i++) seg_r[i] <= init_seg(i);
    end else if (move_s) begin
      seg_r[0] <= {nx_s, ny_s};
      for (int i = 1; i < MAX_LEN; i++) seg_r[i] <= seg_r[i-1];
    end
  end

  // Step timer, direction, growth, length and sticky collision flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_r       <= DIR_RIGHT;
      pend_r      <= DIR_RIGHT;
      grow_pend_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      len_r       <= LEN_INIT;
      step_done_r <= 1'b0;
      hit_wall_r  <= 1'b0;
      hit_body_r  <= 1'b0;
    end else if (bus.restart) begin
      dir_r       <= DIR_RIGHT;
      pend_r      <= DIR_RIGHT;
      grow_pend_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      len_r       <= LEN_INIT;
      step_done_r <= 1'b0;
      hit_wall_r  <= 1'b0;
      hit_body_r  <= 1'b0;
    end else begin
      step_done_r <= move_s;
      if (run_s) begin
        cnt_r <= tick_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      end
      if (tick_s && off_grid_s) begin
        hit_wall_r <= 1'b1;
      end
      if (tick_s && !off_grid_s && body_hit_s) begin
        hit_body_r <= 1'b1;
      end
      if (move_s) begin
        dir_r       <= pend_r;
        grow_pend_r <= 1'b0;
        if (growing_s) begin
          len_r <= len_r + 5'd1;
        end
      end else if (bus.grow && len_room_s) begin
        grow_pend_r <= 1'b1;
      end
      if (key_ok_s) begin
        pend_r <= key_dir_s;
      end
    end
  end

  // Occupancy of the renderer's query cell among active non-head slots.
  always_comb begin
    cell_body_s = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((5'(i) < len_r) && (seg_r[i] == {bus.cell_x, bus.cell_y})) begin
        cell_body_s = 1'b1;
      end else begin
        cell_body_s = cell_body_s;
      end
    end
  end

  assign bus.cell_is_head = (seg_r[0] == {bus.cell_x, bus.cell_y});
  assign bus.cell_is_body = cell_body_s;
  assign bus.head_x       = seg_r[0][10:5];
  assign bus.head_y       = seg_r[0][4:0];
  assign bus.snake_len    = len_r;
  assign bus.step_done    = step_done_r;
  assign bus.hit_wall     = hit_wall_r;
  assign bus.hit_body     = hit_body_r;

endmodule

// File: tb/tb_snake_move_unit.sv
// Directed plus randomized bench for snake_move_unit against a queue-based snake model.
module tb_snake_move_unit;
  localparam int STEP = 4;
  localparam int GW   = 40;
  localparam int GH   = 30;
  localparam int ML   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  snake_move_unit_if sif ();

  snake_move_unit #(
    .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif.slave)
  );

  always #5 clk = ~clk;

  // Model: head at index 0, only live segments are stored; directions 0 up,1 down,2 left,3 right.
  int mx[$];
  int my[$];
  int mdir, mpend, mcnt;
  bit mgrow, mhw, mhb, mdone;

  function automatic int ddx(input int d);
    case (d)
      2: return -1;
      3: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int ddy(input int d);
    case (d)
      0: return -1;
      1: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_init();
    mx = '{20, 19, 18};
    my = '{15, 15, 15};
    mdir = 3; mpend = 3; mcnt = 0;
    mgrow = 0; mhw = 0; mhb = 0; mdone = 0;
  endtask

  task automatic model_clock();
    int  len, nx, ny, kd;
    bit  run, tick, moved, growing, hitb;
    if (!rst || sif.restart) begin
      model_init();
      return;
    end
    len   = mx.size();
    moved = 0;
    mdone = 0;
    run   = (sif.gameStatus == 2'b10) && !mhw && !mhb;
    tick  = run && (mcnt == STEP - 1);
    if (run) mcnt = tick ? 0 : mcnt + 1;
    growing = mgrow || (sif.grow && len < ML);
    if (tick) begin
      nx = mx[0] + ddx(mpend);
      ny = my[0] + ddy(mpend);
`ifdef WRAP_WALLS_EN
      nx = (nx + GW) % GW;
      ny = (ny + GH) % GH;
`endif
      if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
        mhw = 1;
      end else begin
        hitb = 0;
        for (int i = 1; i < len; i++)
          if (mx[i] == nx && my[i] == ny && (i < len - 1 || growing)) hitb = 1;
        if (hitb) begin
          mhb = 1;
        end else begin
          mx.push_front(nx);
          my.push_front(ny);
          if (!growing) begin
            void'(mx.pop_back());
            void'(my.pop_back());
          end
          mgrow = 0;
          mdir  = mpend;
          mdone = 1;
          moved = 1;
        end
      end
    end
    if (!moved && sif.grow && len < ML) mgrow = 1;
    kd = -1;
    if (sif.key1_press)      kd = 0;
    else if (sif.key2_press) kd = 1;
    else if (sif.key3_press) kd = 2;
    else if (sif.key4_press) kd = 3;
    if (kd >= 0 && kd != opposite(mdir)) mpend = kd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: advance model, clock DUT, compare outputs, clear pulses, probe a cell.
  task automatic cyc();
    int  qi;
    bit  eh, eb;
    model_clock();
    @(posedge clk);
    #1;
    chk("head_x", 32'(sif.head_x), 32'(mx[0]));
    chk("head_y", 32'(sif.head_y), 32'(my[0]));
    chk("snake_len", 32'(sif.snake_len), 32'(mx.size()));
    chk("step_done", 32'(sif.step_done), 32'(mdone));
    chk("hit_wall", 32'(sif.hit_wall), 32'(mhw));
    chk("hit_body", 32'(sif.hit_body), 32'(mhb));
    sif.key1_press = 1'b0; sif.key2_press = 1'b0;
    sif.key3_press = 1'b0; sif.key4_press = 1'b0;
    sif.grow = 1'b0; sif.restart = 1'b0;
    qi = $urandom_range(0, ML);
    if (qi < mx.size()) begin
      sif.cell_x = 6'(mx[qi]);
      sif.cell_y = 5'(my[qi]);
    end else begin
      sif.cell_x = 6'($urandom_range(0, 63));
      sif.cell_y = 5'($urandom_range(0, 31));
    end
    #1;
    eh = (mx[0] == int'(sif.cell_x)) && (my[0] == int'(sif.cell_y));
    eb = 0;
    for (int i = 1; i < mx.size(); i++)
      if (mx[i] == int'(sif.cell_x) && my[i] == int'(sif.cell_y)) eb = 1;
    chk("cell_is_head", 32'(sif.cell_is_head), 32'(eh));
    chk("cell_is_body", 32'(sif.cell_is_body), 32'(eb));
  endtask

  task automatic probe(input int x, input int y, input bit exp_body, input string tag);
    sif.cell_x = 6'(x);
    sif.cell_y = 5'(y);
    #1;
    chk(tag, 32'(sif.cell_is_body), 32'(exp_body));
  endtask

  initial begin
    sif.gameStatus = 2'b00; sif.restart = 1'b0; sif.grow = 1'b0;
    sif.key1_press = 1'b0; sif.key2_press = 1'b0;
    sif.key3_press = 1'b0; sif.key4_press = 1'b0;
    sif.cell_x = 6'd0; sif.cell_y = 5'd0;
    model_init();

    rst = 1'b0;
    cyc(); cyc();
    chk("rst_head_x", 32'(sif.head_x), 32'd20);
    chk("rst_head_y", 32'(sif.head_y), 32'd15);
    chk("rst_len", 32'(sif.snake_len), 32'd3);
    rst = 1'b1;

    sif.gameStatus = 2'b10;
    repeat (3) cyc();
    chk("first_step_not_yet", 32'(sif.step_done), 32'd0);
    cyc();
    chk("first_step_done", 32'(sif.step_done), 32'd1);
    chk("first_step_x", 32'(sif.head_x), 32'd21);
    repeat (8) cyc();
    chk("third_step_x", 32'(sif.head_x), 32'd23);
    chk("third_step_y", 32'(sif.head_y), 32'd15);

    sif.key3_press = 1'b1; cyc();
    sif.key1_press = 1'b1; cyc();
    cyc(); cyc();
    chk("turn_up_x", 32'(sif.head_x), 32'd23);
    chk("turn_up_y", 32'(sif.head_y), 32'd14);

    sif.key4_press = 1'b1; cyc();
    repeat (67) cyc();
`ifdef WRAP_WALLS_EN
    chk("wrap_x", 32'(sif.head_x), 32'd0);
    chk("wrap_no_wall", 32'(sif.hit_wall), 32'd0);
`else
    chk("wall_hit", 32'(sif.hit_wall), 32'd1);
    chk("wall_head_x", 32'(sif.head_x), 32'd39);
    repeat (8) cyc();
    chk("wall_frozen_x", 32'(sif.head_x), 32'd39);
    chk("wall_no_step", 32'(sif.step_done), 32'd0);
`endif

    sif.restart = 1'b1; cyc();
    chk("restart_x", 32'(sif.head_x), 32'd20);
    chk("restart_len", 32'(sif.snake_len), 32'd3);
    chk("restart_wall", 32'(sif.hit_wall), 32'd0);

    sif.grow = 1'b1; cyc();
    repeat (3) cyc();
    chk("grow_len", 32'(sif.snake_len), 32'd4);
    probe(18, 15, 1'b1, "grow_old_tail");
    probe(0, 0, 1'b0, "grow_masked_slot");
    repeat (13) begin
      sif.grow = 1'b1; cyc();
      repeat (3) cyc();
    end
    chk("grow_saturate", 32'(sif.snake_len), 32'd16);
    chk("grow_head_x", 32'(sif.head_x), 32'd34);

    sif.restart = 1'b1; cyc();
    repeat (2) begin
      sif.grow = 1'b1; cyc();
      repeat (3) cyc();
    end
    chk("len5", 32'(sif.snake_len), 32'd5);
    sif.key1_press = 1'b1; cyc(); repeat (3) cyc();
    sif.key3_press = 1'b1; cyc(); repeat (3) cyc();
    sif.key2_press = 1'b1; cyc(); repeat (3) cyc();
    chk("self_hit", 32'(sif.hit_body), 32'd1);
    chk("self_hit_x", 32'(sif.head_x), 32'd21);
    chk("self_hit_y", 32'(sif.head_y), 32'd14);

    sif.restart = 1'b1; cyc();
    sif.grow = 1'b1; cyc(); repeat (3) cyc();
    repeat (2) begin
      sif.key1_press = 1'b1; cyc(); repeat (3) cyc();
      sif.key3_press = 1'b1; cyc(); repeat (3) cyc();
      sif.key2_press = 1'b1; cyc(); repeat (3) cyc();
      sif.key4_press = 1'b1; cyc(); repeat (3) cyc();
    end
    chk("chase_no_hit", 32'(sif.hit_body), 32'd0);
    chk("chase_x", 32'(sif.head_x), 32'd21);
    chk("chase_y", 32'(sif.head_y), 32'd15);

    sif.gameStatus = 2'b01;
    repeat (10) cyc();
    chk("hold_x", 32'(sif.head_x), 32'd21);
    sif.gameStatus = 2'b10;

    repeat (800) begin
      sif.gameStatus = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      sif.key1_press = ($urandom_range(0, 7) == 0);
      sif.key2_press = ($urandom_range(0, 7) == 0);
      sif.key3_press = ($urandom_range(0, 7) == 0);
      sif.key4_press = ($urandom_range(0, 7) == 0);
      sif.grow       = ($urandom_range(0, 5) == 0);
      sif.restart    = ((mhw || mhb) && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) rst = 1'b0;
      cyc();
      rst = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
